// File: rtl/ising_pkg.sv
// Shared types and defaults for the Ising sampler stages.
package ising_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

    // Loop stage and spin-update stage must agree on these.
    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_DATABITS = 16;

    // One step of the 16-bit right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/spin_update_if.sv
// Field-vector handshake in, spin vector out, for the spin-update stage.
interface spin_update_if import ising_pkg::*; #(
    parameter int N        = DEFAULT_N,
    parameter int DATABITS = DEFAULT_DATABITS
);
    logic [DATABITS*N-1:0] field_in;
    logic                  field_valid;
    logic                  field_ready;
    logic [3:0]            temp_shift;
    logic [N-1:0]          spins_out;
    logic                  spins_valid;
    logic [15:0]           sweep_count;

    modport master (
        output field_in, field_valid, temp_shift,
        input  field_ready, spins_out, spins_valid, sweep_count
    );

    modport slave (
        input  field_in, field_valid, temp_shift,
        output field_ready, spins_out, spins_valid, sweep_count
    );
endinterface

// File: rtl/spin_update_lfsr16.sv
// 16-bit Galois LFSR; q is the current value, advanced by en.
module lfsr16 import ising_pkg::*; #(
    parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] q
);
    // An all-zero seed would lock the register at zero.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q, lfsr_d;

    // Next value: one Galois step when enabled, otherwise hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // LFSR register, reseeded by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;
endmodule

// File: rtl/spin_update.sv
// Spin-update stage: serially thresholds a captured field snapshot against
// temperature-scaled LFSR noise, one spin per cycle.
module spin_update import ising_pkg::*; #(
    parameter int           N         = DEFAULT_N,
    parameter int           DATABITS  = DEFAULT_DATABITS,
    parameter logic [N-1:0] SPIN_INIT = N'(4'b0101),
    parameter logic [15:0]  LFSR_SEED = DEFAULT_LFSR_SEED
) (
    input logic            clk,
    input logic            rst_n,
    spin_update_if.slave   bus
);
    localparam int             IDXW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_t                state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [DATABITS*N-1:0] field_q, field_d;
    logic [3:0]            temp_q, temp_d;
    logic [N-1:0]          spins_q, spins_d;
    logic                  valid_q, valid_d;
    logic [15:0]           count_q, count_d;

    logic [15:0]           lfsr;
    logic                  lfsr_en;

    logic [DATABITS-1:0]   lane;
    logic signed [15:0]    noise16;
    logic signed [DATABITS:0] field_ext;
    logic signed [DATABITS:0] noise_ext;
    logic                  spin_up;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .q     (lfsr)
    );

    // Comparator: field lane idx against shifted noise, both widened to DATABITS+1.
    always_comb begin
        lane      = field_q[idx_q*DATABITS +: DATABITS];
        noise16   = $signed(lfsr) >>> temp_q;
        field_ext = {lane[DATABITS-1], lane};
        noise_ext = {{(DATABITS-15){noise16[15]}}, noise16};
        spin_up   = field_ext > noise_ext;
    end

    // FSM next-state, snapshot capture, spin write and sweep bookkeeping.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        field_d = field_q;
        temp_d  = temp_q;
        spins_d = spins_q;
        valid_d = 1'b0;
        count_d = count_q;
        lfsr_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.field_valid) begin
                    field_d = bus.field_in;
                    temp_d  = bus.temp_shift;
                    idx_d   = '0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                spins_d[idx_q] = spin_up;
                lfsr_en        = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    valid_d = 1'b1;
                    count_d = count_q + 16'd1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            field_q <= '0;
            temp_q  <= '0;
            spins_q <= SPIN_INIT;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            field_q <= field_d;
            temp_q  <= temp_d;
            spins_q <= spins_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.field_ready = (state_q == IDLE);
    assign bus.spins_out   = spins_q;
    assign bus.spins_valid = valid_q;
    assign bus.sweep_count = count_q;
endmodule

// File: tb/tb_spin_update.sv
// Directed bench for spin_update with hand-computed sweep results.
module tb_spin_update;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    spin_update_if bus ();

    spin_update dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_lanes(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    task automatic do_reset();
        bus.field_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Accept one vector and follow the sweep through DONE back to IDLE.
    // hold keeps field_valid high afterwards; busy injects a vector mid-sweep.
    task automatic run_sweep(input string name, input logic [63:0] fv, input logic [3:0] ts,
                             input logic hold, input logic busy, input logic [63:0] busy_fv,
                             input logic [3:0] exp_spins, input logic [15:0] exp_count);
        int pulse_at;
        int pulses;
        pulse_at = 0;
        pulses   = 0;
        check({name, "_ready_pre"}, 32'(bus.field_ready), 32'd1);
        bus.field_in    = fv;
        bus.temp_shift  = ts;
        bus.field_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.field_valid = 1'b0;
        check({name, "_ready_busy"}, 32'(bus.field_ready), 32'd0);
        for (int i = 1; i <= N + 1; i++) begin
            @(posedge clk);
            #1;
            if (busy && i == 2) begin
                bus.field_in    = busy_fv;
                bus.temp_shift  = 4'd15;
                bus.field_valid = 1'b1;
            end
            if (bus.spins_valid) begin
                pulses++;
                if (pulse_at == 0) pulse_at = i;
                check({name, "_spins"}, 32'(bus.spins_out), 32'(exp_spins));
                check({name, "_count"}, 32'(bus.sweep_count), 32'(exp_count));
            end
            if (i <= N) check({name, "_ready_low"}, 32'(bus.field_ready), 32'd0);
        end
        check({name, "_pulse_at"}, 32'(pulse_at), 32'(N));
        check({name, "_pulses"}, 32'(pulses), 32'd1);
        check({name, "_ready_back"}, 32'(bus.field_ready), 32'd1);
    endtask

    initial begin
        bus.field_in    = '0;
        bus.temp_shift  = '0;
        bus.field_valid = 1'b0;
        do_reset();

        check("rst_spins", 32'(bus.spins_out), 32'h5);
        check("rst_ready", 32'(bus.field_ready), 32'd1);
        check("rst_count", 32'(bus.sweep_count), 32'd0);
        check("rst_valid", 32'(bus.spins_valid), 32'd0);

        // Noise ACE1, E270, 7138, 389C against zero fields.
        run_sweep("golden", all_lanes(16'h0000), 4'd0, 1'b0, 1'b0, '0, 4'b0011, 16'd1);
        // Continues from 1C4E: noise 1C4E, 0E27, B313, ED89.
        run_sweep("golden_next", all_lanes(16'h0000), 4'd0, 1'b0, 1'b0, '0, 4'b1100, 16'd2);

        run_sweep("pos", all_lanes(16'sh03E8), 4'd15, 1'b0, 1'b0, '0, 4'b1111, 16'd3);
        run_sweep("neg", all_lanes(16'hFC18), 4'd15, 1'b1, 1'b0, '0, 4'b0000, 16'd4);
        run_sweep("neg_b2b", all_lanes(16'hFC18), 4'd15, 1'b0, 1'b0, '0, 4'b0000, 16'd5);

        // Mid-sweep vector must not disturb the running sweep, then lands after DONE.
        run_sweep("busy", all_lanes(16'h03E8), 4'd15, 1'b0, 1'b1, all_lanes(16'hFC18),
                  4'b1111, 16'd6);
        run_sweep("busy_next", all_lanes(16'hFC18), 4'd15, 1'b0, 1'b0, '0, 4'b0000, 16'd7);

        // Reset part-way through a golden sweep.
        do_reset();
        bus.field_in    = all_lanes(16'h0000);
        bus.temp_shift  = 4'd0;
        bus.field_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.field_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("mid_partial", 32'(bus.spins_out), 32'h7);
        rst_n = 1'b0;
        #1;
        check("mid_rst_spins", 32'(bus.spins_out), 32'h5);
        check("mid_rst_count", 32'(bus.sweep_count), 32'd0);
        check("mid_rst_ready", 32'(bus.field_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("mid_rst_valid", 32'(bus.spins_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        run_sweep("mid_golden", all_lanes(16'h0000), 4'd0, 1'b0, 1'b0, '0, 4'b0011, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
